// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the 16-bit adder datapath and its consumers.
//   - ST_IDLE / ST_ACCUM / ST_DONE : accumulator FSM encoding (2-bit binary)
//   - ADDER_WIDTH / ACC_WIDTH      : default adder and accumulator widths
package adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int ADDER_WIDTH = 16;
    localparam int ACC_WIDTH   = 24;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } acc_state_t;

endpackage

// File: rtl/adder_beat_counter.sv
// adder_beat_counter
//   Counts accepted beats within a burst.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     clr       : synchronous clear (wins over en)
//     en        : count one beat this cycle
//     count     : beats counted so far
//     last      : next counted beat is beat number COUNT_MAX
module adder_beat_counter
    import adder_pkg::*;
#(
    parameter int COUNT_MAX = 16,
    parameter int CW        = $clog2(COUNT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational look-ahead so the FSM can leave ACCUM on the same
    // edge that accepts the terminal beat.
    assign last  = (r_count == CW'(COUNT_MAX - 1));
    assign count = r_count;

endmodule

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//   Sums a burst of COUNT_MAX {cout, sum} adder results into an
//   ACC_WIDTH accumulator over a valid/ready handshake.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : one-cycle pulse; clears and (re)starts a burst
//     in_valid  : sum/cout carry a valid result
//     in_ready  : registered, high only while accumulating
//     sum, cout : adder result
//     acc       : running total (mod 2^ACC_WIDTH)
//     count     : beats accepted in the current burst
//     done      : burst complete, held until start or rst
//     ovf       : sticky accumulator overflow for the burst
module adder_result_accumulator #(
    parameter int WIDTH     = adder_pkg::ADDER_WIDTH,
    parameter int ACC_WIDTH = adder_pkg::ACC_WIDTH,
    parameter int COUNT_MAX = 16,
    parameter int CW        = $clog2(COUNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [CW-1:0]        count,
    output logic                 done,
    output logic                 ovf
);

    import adder_pkg::*;

    localparam int AW1 = ACC_WIDTH + 1;

    acc_state_t           r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic                 r_done;
    logic                 r_in_ready;

    logic                 w_beat;
    logic                 w_last;
    logic [AW1-1:0]       w_total;

    // A start in ACCUM drops any beat on the same edge.
    assign w_beat  = in_valid && r_in_ready && !start;
    // One extra bit captures the carry out of the accumulator.
    assign w_total = {1'b0, r_acc} + AW1'({cout, sum});

    adder_beat_counter #(
        .COUNT_MAX (COUNT_MAX),
        .CW        (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (w_beat),
        .count (count),
        .last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_ACCUM;
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        r_done     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end else if (w_beat) begin
                        r_acc <= w_total[ACC_WIDTH-1:0];
                        if (w_total[ACC_WIDTH]) r_ovf <= 1'b1;
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign acc      = r_acc;
    assign ovf      = r_ovf;
    assign done     = r_done;
    assign in_ready = r_in_ready;

endmodule

// File: tb/tb_adder_result_accumulator.sv
module tb_adder_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    // default instance: ACC_WIDTH=24, COUNT_MAX=16
    logic        start, in_valid, cout;
    logic [15:0] sum;
    logic        in_ready, done, ovf;
    logic [23:0] acc;
    logic [4:0]  count;
    // narrow instance: ACC_WIDTH=18, COUNT_MAX=3
    logic        start1, in_valid1, cout1;
    logic [15:0] sum1;
    logic        in_ready1, done1, ovf1;
    logic [17:0] acc1;
    logic [1:0]  count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_result_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .sum(sum), .cout(cout), .acc(acc),
        .count(count), .done(done), .ovf(ovf)
    );

    adder_result_accumulator #(.WIDTH(16), .ACC_WIDTH(18), .COUNT_MAX(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
        .in_ready(in_ready1), .sum(sum1), .cout(cout1), .acc(acc1),
        .count(count1), .done(done1), .ovf(ovf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic v, input logic [15:0] s, input logic c);
        in_valid = v; sum = s; cout = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; in_valid = 0; sum = 0; cout = 0;
        start1 = 0; in_valid1 = 0; sum1 = 0; cout1 = 0;
        tick(); tick();
        checks++;
        if (acc !== 24'h0 || count !== 5'd0 || done !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: acc=%h count=%0d done=%b ovf=%b rdy=%b, want all 0", acc, count, done, ovf, in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || acc1 !== 18'h0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b acc1=%h rdy1=%b, want 0", in_ready, acc1, in_ready1);
        end
    endtask

    task automatic test_normal();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || acc !== 24'h0 || count !== 5'd0) begin
            errors++;
            $display("FAIL normal_start: rdy=%b acc=%h count=%0d, want 1/0/0", in_ready, acc, count);
        end
        for (int i = 1; i <= 16; i++) begin
            beat(1'b1, 16'(2 * i), 1'b0);
            if (i == 15) begin
                checks++;
                if (count !== 5'd15 || done !== 1'b0 || acc !== 24'h0000F0) begin
                    errors++;
                    $display("FAIL normal_beat15: count=%0d done=%b acc=%h, want 15/0/0000f0", count, done, acc);
                end
            end
        end
        checks++;
        if (acc !== 24'h000110 || count !== 5'd16 || done !== 1'b1 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_end: acc=%h count=%0d done=%b ovf=%b rdy=%b, want 000110/16/1/0/0", acc, count, done, ovf, in_ready);
        end
    endtask

    task automatic test_carry();
        pulse_start();
        checks++;
        if (done !== 1'b0 || acc !== 24'h0) begin
            errors++;
            $display("FAIL carry_start: done=%b acc=%h, want 0/0", done, acc);
        end
        for (int i = 0; i < 16; i++) beat(1'b1, 16'hFFFE, 1'b1);
        checks++;
        if (acc !== 24'h1FFFE0 || ovf !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL carry_end: acc=%h ovf=%b done=%b, want 1fffe0/0/1", acc, ovf, done);
        end
        beat(1'b1, 16'h1234, 1'b1);
        tick();
        checks++;
        if (acc !== 24'h1FFFE0 || count !== 5'd16 || done !== 1'b1) begin
            errors++;
            $display("FAIL carry_extra_ignored: acc=%h count=%0d done=%b, want 1fffe0/16/1", acc, count, done);
        end
    endtask

    task automatic test_overflow();
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid1 = 1'b1; sum1 = 16'hFFFE; cout1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            if (i == 2) begin
                checks++;
                if (acc1 !== 18'h3FFFC || ovf1 !== 1'b0 || done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_beat2: acc=%h ovf=%b done=%b, want 3fffc/0/0", acc1, ovf1, done1);
                end
            end
        end
        checks++;
        if (acc1 !== 18'h1FFFA || ovf1 !== 1'b1 || done1 !== 1'b1 || count1 !== 2'd3 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end: acc=%h ovf=%b done=%b count=%0d rdy=%b, want 1fffa/1/1/3/0", acc1, ovf1, done1, count1, in_ready1);
        end
        tick();
        checks++;
        if (ovf1 !== 1'b1 || acc1 !== 18'h1FFFA) begin
            errors++;
            $display("FAIL ovf_hold: ovf=%b acc=%h, want 1/1fffa", ovf1, acc1);
        end
        start1 = 1'b1; tick(); start1 = 1'b0;
        checks++;
        if (ovf1 !== 1'b0 || acc1 !== 18'h0 || done1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_restart_clear: ovf=%b acc=%h done=%b rdy=%b, want 0/0/0/1", ovf1, acc1, done1, in_ready1);
        end
    endtask

    task automatic test_stalls();
        int n;
        int k;
        n = 0; k = 0;
        pulse_start();
        while (n < 16 && k < 100) begin
            logic v;
            v = (k % 3 == 0);
            beat(v, 16'h0001, 1'b0);
            if (v) n++;
            k++;
            checks++;
            if (count !== 5'(n) || acc !== 24'(n)) begin
                errors++;
                $display("FAIL stall_cycle%0d: count=%0d acc=%h, want %0d/%h", k, count, acc, n, 24'(n));
            end
        end
        checks++;
        if (acc !== 24'h000010 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: acc=%h done=%b, want 000010/1", acc, done);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 5; i++) beat(1'b1, 16'h0001, 1'b0);
        checks++;
        if (count !== 5'd5 || acc !== 24'h5) begin
            errors++;
            $display("FAIL restart_pre: count=%0d acc=%h, want 5/5", count, acc);
        end
        start = 1'b1; in_valid = 1'b1; sum = 16'h0100; cout = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (acc !== 24'h0 || count !== 5'd0 || ovf !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: acc=%h count=%0d ovf=%b rdy=%b done=%b, want 0/0/0/1/0", acc, count, ovf, in_ready, done);
        end
        for (int i = 0; i < 16; i++) beat(1'b1, 16'h0001, 1'b0);
        checks++;
        if (acc !== 24'h10 || done !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL restart_end: acc=%h done=%b count=%0d, want 10/1/16", acc, done, count);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) beat(1'b1, 16'h0003, 1'b0);
        checks++;
        if (acc !== 24'h15 || count !== 5'd7) begin
            errors++;
            $display("FAIL areset_pre: acc=%h count=%0d, want 15/7", acc, count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (acc !== 24'h0 || count !== 5'd0 || in_ready !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: acc=%h count=%0d rdy=%b done=%b ovf=%b, want 0", acc, count, in_ready, done, ovf);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || acc !== 24'h0) begin
            errors++;
            $display("FAIL areset_start_loses: rdy=%b acc=%h, want 0/0", in_ready, acc);
        end
        for (int i = 0; i < 4; i++) beat(1'b1, 16'hABCD, 1'b1);
        checks++;
        if (acc !== 24'h0 || count !== 5'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle_hold: acc=%h count=%0d rdy=%b done=%b, want 0", acc, count, in_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_carry();
        test_overflow();
        test_stalls();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
